// File: rtl/tx_scheduler.sv
// Two-queue round-robin transmit scheduler: grants one queue at a time for up to
// BURST words, hands each word to the transmitter, then idles GAP cycles.
module tx_scheduler #(
  parameter int unsigned BURST = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        q0_state,
  input  logic [11:0] q0_data,
  input  logic [5:0]  q0_occ,
  output logic        q0_ren,
  input  logic        q1_state,
  input  logic [11:0] q1_data,
  input  logic [5:0]  q1_occ,
  output logic        q1_ren,
  output logic        tx_valid,
  output logic [11:0] tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        owner,
  output logic        busy
);

  localparam logic [3:0] BurstW = 4'(BURST);
  localparam logic [3:0] GapW   = 4'(GAP);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StGap} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        owner_q, owner_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic [11:0] tx_data_q, tx_data_d;

  logic        sel_state;
  logic [11:0] sel_data;
  logic [5:0]  sel_occ;
  logic [3:0]  cnt_inc;
  logic [3:0]  gap_inc;
  logic        xfer;

  assign sel_state = owner_q ? q1_state : q0_state;
  assign sel_data  = owner_q ? q1_data  : q0_data;
  assign sel_occ   = owner_q ? q1_occ   : q0_occ;
  assign cnt_inc   = cnt_q + 4'd1;
  assign gap_inc   = gap_q + 4'd1;
  assign xfer      = tx_valid_q && tx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    owner_d    = owner_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    tx_data_d  = tx_data_q;
    q0_ren     = 1'b0;
    q1_ren     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (q0_state || q1_state) begin
          // On a tie the queue not served last wins.
          owner_d = (q0_state && q1_state) ? ~owner_q : q1_state;
          cnt_d   = 4'd0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!sel_state) begin
          state_d = StIdle;
        end else begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          tx_last_d  = (cnt_inc == BurstW) || (sel_occ == 6'd1);
          cnt_d      = cnt_inc;
          q0_ren     = ~owner_q;
          q1_ren     = owner_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          if (!tx_last_q) begin
            state_d = StLoad;
          end else if (GAP == 0) begin
            state_d = StIdle;
          end else begin
            gap_d   = 4'd0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        // Fixed length: queue activity during the gap is deliberately ignored.
        if (gap_inc == GapW) begin
          gap_d   = 4'd0;
          state_d = StIdle;
        end else begin
          gap_d = gap_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      gap_q      <= 4'd0;
      owner_q    <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= 12'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      owner_q    <= owner_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign tx_data  = tx_data_q;
  assign owner    = owner_q;
  assign busy     = (state_q != StIdle);

endmodule
